// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU request/response sequencer.
// Holds the ALU opcode set, sequencer FSM states and the unit shift operand.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_LSH = 3'b001,
        OP_RSH = 3'b010,
        OP_XOR = 3'b011,
        OP_ORR = 3'b100,
        OP_SUB = 3'b101,
        OP_RSV = 3'b110,
        OP_RXR = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } seq_state_e;

    localparam logic [7:0] SHIFT_ONE = 8'h01;

    function automatic logic is_shift(alu_op_e op);
        return (op == OP_LSH) || (op == OP_RSH);
    endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of one ALU pass, used to cross-check AluOut.
// Shifts are single-bit passes; the reserved opcode echoes operand A.
module alu_ref_model
    import alu_pkg::*;
(
    input  alu_op_e    op_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       sc_i,
    output logic [7:0] res_o
);

    always_comb begin
        res_o = a_i;
        case (op_i)
            OP_ADD:  res_o = a_i + b_i;
            OP_LSH:  res_o = {a_i[6:0], sc_i};
            OP_RSH:  res_o = {1'b0, a_i[7:1]};
            OP_XOR:  res_o = a_i ^ b_i;
            OP_ORR:  res_o = a_i | b_i;
            OP_SUB:  res_o = a_i - b_i;
            OP_RXR:  res_o = {7'b0, ^a_i};
            default: res_o = a_i;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Valid/ready front-end driving a combinational 8-bit ALU; multi-bit shifts
// iterate single-bit passes. Define ALU_SEQ_CHECK_EN to cross-check AluOut.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int SHIFT_W = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ReqValid,
    output logic       ReqReady,
    input  logic [2:0] ReqOp,
    input  logic [7:0] ReqA,
    input  logic [7:0] ReqB,
    input  logic       ReqSC,
    output logic       RspValid,
    input  logic       RspReady,
    output logic [7:0] RspData,
    output logic       RspZero,
    output logic       RspErr,
    output logic [7:0] AluA,
    output logic [7:0] AluB,
    output logic       AluSC,
    output logic [2:0] AluOp,
    input  logic [7:0] AluOut,
    input  logic       AluZero
);

    seq_state_e         state_q;
    logic [SHIFT_W-1:0] cnt_q;
    logic [SHIFT_W-1:0] cnt_d;
    logic [7:0]         acc_q;
    logic               zero_q;
    logic [7:0]         alu_a_q;
    logic [7:0]         alu_b_q;
    logic               alu_sc_q;
    alu_op_e            alu_op_q;
    logic               rsp_valid_q;
    logic               req_ready_q;
    alu_op_e            req_op;
    logic               accept;

    assign req_op = alu_op_e'(ReqOp);
    assign accept = (state_q == S_IDLE) && ReqValid && req_ready_q;
    assign cnt_d  = is_shift(req_op) ? ReqB[SHIFT_W-1:0] : SHIFT_W'(1);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= 8'h00;
            zero_q      <= 1'b0;
            alu_a_q     <= 8'h00;
            alu_b_q     <= 8'h00;
            alu_sc_q    <= 1'b0;
            alu_op_q    <= OP_ADD;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        if (cnt_d == '0) begin
                            acc_q       <= ReqA;
                            zero_q      <= (ReqA == 8'h00);
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else begin
                            cnt_q    <= cnt_d;
                            alu_a_q  <= ReqA;
                            alu_b_q  <= is_shift(req_op) ? SHIFT_ONE : ReqB;
                            alu_sc_q <= (req_op == OP_LSH) && ReqSC;
                            alu_op_q <= req_op;
                            state_q  <= S_EXEC;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    acc_q  <= AluOut;
                    zero_q <= AluZero;
                    cnt_q  <= cnt_q - 1'b1;
                    // AluA keeps the final pass's operand once we leave EXEC
                    if (cnt_q == SHIFT_W'(1)) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        alu_a_q <= AluOut;
                    end
                end
                S_RESP: begin
                    if (RspReady) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_CHECK_EN
    logic [7:0] exp_res;
    logic       pass_err_d;
    logic       err_q;

    alu_ref_model u_ref (
        .op_i  (alu_op_q),
        .a_i   (alu_a_q),
        .b_i   (alu_b_q),
        .sc_i  (alu_sc_q),
        .res_o (exp_res)
    );

    assign pass_err_d = (exp_res != AluOut) || (alu_op_q == OP_RSV);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (state_q == S_EXEC) begin
            err_q <= err_q | pass_err_d;
        end
    end

    assign RspErr = err_q;
`else
    assign RspErr = 1'b0;
`endif

    assign ReqReady = req_ready_q;
    assign RspValid = rsp_valid_q;
    assign RspData  = acc_q;
    assign RspZero  = zero_q;
    assign AluA     = alu_a_q;
    assign AluB     = alu_b_q;
    assign AluSC    = alu_sc_q;
    assign AluOp    = alu_op_q;

endmodule
